// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Generates a divided clock (oDIV_CLK) and a period-start pulse (oTICK) from
// CLK, with a start/stop FSM and a shadowed divisor register that is only
// applied on a period boundary, so a running clock never sees a partial period.
//
// Handshake: a divisor transfer happens on a rising edge of CLK where
// iDIV_VALID and oDIV_READY are both 1. oDIV_READY is the inverse of the
// shadow "pending" flag and does not depend on iDIV_VALID. A transferred value
// below 2 completes the handshake, is dropped, and sets the sticky oERR.
//
// Ports:
//   CLK         in   single clock, rising edge
//   RST_N       in   synchronous active-low reset
//   iSTART      in   request to start the divided clock
//   iSTOP       in   request to stop at the end of the current period
//   iDIV        in   [WIDTH] new divisor value
//   iDIV_VALID  in   iDIV is valid
//   oDIV_READY  out  shadow register empty, can accept a divisor
//   oDIV_CLK    out  divided clock (registered)
//   oTICK       out  one-cycle pulse at each divided period start (registered)
//   oBUSY       out  FSM not IDLE
//   oDIV_CUR    out  [WIDTH] divisor currently in effect
//   oERR        out  sticky illegal-divisor flag
//   oSTATE      out  [2] FSM state for debug/observation (0 IDLE, 1 RUN,
//                    2 STOPPING)
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             iSTART,
    input  logic             iSTOP,
    input  logic [WIDTH-1:0] iDIV,
    input  logic             iDIV_VALID,
    output logic             oDIV_READY,
    output logic             oDIV_CLK,
    output logic             oTICK,
    output logic             oBUSY,
    output logic [WIDTH-1:0] oDIV_CUR,
    output logic             oERR,
    output logic [1:0]       oSTATE
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] div_q,     div_d;
    logic [WIDTH-1:0] shadow_q,  shadow_d;
    logic             pending_q, pending_d;
    logic             err_q,     err_d;
    logic             div_clk_q, div_clk_d;
    logic             tick_q,    tick_d;

    logic             active;
    logic             at_last;
    logic             start_only;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] high_len;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        err_d      = err_q;
        div_clk_d  = 1'b0;
        tick_d     = 1'b0;
        high_len   = '0;

        active     = (state_q != ST_IDLE);
        // Last cycle of the current period; the next edge is a boundary.
        at_last    = active && (cnt_q == (div_q - WIDTH'(1)));
        // Stop always wins over a simultaneous start.
        start_only = iSTART && !iSTOP;
        xfer       = iDIV_VALID && !pending_q;
        // Shadow applies immediately when idle, otherwise only on a boundary.
        load       = pending_q && (!active || at_last);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_only) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = at_last ? '0 : cnt_q + WIDTH'(1);
                if (iSTOP) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                cnt_d = at_last ? '0 : cnt_q + WIDTH'(1);
                // A restart takes priority over finishing the stop, even on
                // the boundary cycle.
                if (start_only) begin
                    state_d = ST_RUN;
                end else if (at_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            div_d     = shadow_q;
            pending_d = 1'b0;
        end

        // xfer requires pending_q == 0, so it never overlaps a load.
        if (xfer) begin
            if (iDIV >= WIDTH'(2)) begin
                shadow_d  = iDIV;
                pending_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // Outputs are registered, so they are computed from the next state,
        // the next count and the divisor that will be in effect.
        high_len = div_d - (div_d >> 1);
        if (state_d != ST_IDLE) begin
            div_clk_d = (cnt_d < high_len);
            tick_d    = (cnt_d == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= WIDTH'(DEFAULT_DIV);
            shadow_q  <= WIDTH'(DEFAULT_DIV);
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign oDIV_READY = !pending_q;
    assign oDIV_CLK   = div_clk_q;
    assign oTICK      = tick_q;
    assign oBUSY      = (state_q != ST_IDLE);
    assign oDIV_CUR   = div_q;
    assign oERR       = err_q;
    assign oSTATE     = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Directed steps followed by a randomized phase. Every cycle the DUT outputs
// are compared with a behavioural model that tracks mode, period position,
// divisor, pending shadow value and error flag using plain integer arithmetic.
// Directed waveform segments are also compared against literal patterns held
// in an expected queue.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int WIDTH = 8;
    localparam int DEF   = 8;

    // ---------------- clock / reset ----------------
    logic             CLK = 1'b0;
    logic             RST_N;
    logic             iSTART;
    logic             iSTOP;
    logic [WIDTH-1:0] iDIV;
    logic             iDIV_VALID;
    logic             oDIV_READY;
    logic             oDIV_CLK;
    logic             oTICK;
    logic             oBUSY;
    logic [WIDTH-1:0] oDIV_CUR;
    logic             oERR;
    logic [1:0]       oSTATE;

    always #5 CLK = ~CLK;

    clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .iSTART     (iSTART),
        .iSTOP      (iSTOP),
        .iDIV       (iDIV),
        .iDIV_VALID (iDIV_VALID),
        .oDIV_READY (oDIV_READY),
        .oDIV_CLK   (oDIV_CLK),
        .oTICK      (oTICK),
        .oBUSY      (oBUSY),
        .oDIV_CUR   (oDIV_CUR),
        .oERR       (oERR),
        .oSTATE     (oSTATE)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];   // {ready, div_clk, tick} for directed segments

    // Model: mode 0 = stopped, 1 = running, 2 = running but stop requested.
    int m_mode;
    int m_cnt;
    int m_d;
    int m_shadow;
    bit m_pend;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(input bit rst_n, input bit start, input bit stop,
                                       input bit valid, input int div);
        int  next_mode;
        bit  period_end;
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_d = DEF; m_pend = 0; m_err = 0;
            return;
        end
        period_end = (m_mode != 0) && (m_cnt == m_d - 1);
        if (m_mode == 0)      next_mode = (start && !stop) ? 1 : 0;
        else if (m_mode == 1) next_mode = stop ? 2 : 1;
        else                  next_mode = (start && !stop) ? 1 : (period_end ? 0 : 2);
        if (m_mode == 0 || next_mode == 0) m_cnt = 0;
        else                               m_cnt = period_end ? 0 : m_cnt + 1;
        if (m_pend && (m_mode == 0 || period_end)) begin
            m_d = m_shadow;
            m_pend = 0;
        end else if (valid && !m_pend) begin
            if (div >= 2) begin
                m_shadow = div;
                m_pend = 1;
            end else begin
                m_err = 1;
            end
        end
        m_mode = next_mode;
    endfunction

    task automatic check_outputs();
        bit run;
        run = (m_mode != 0);
        check("ready", oDIV_READY, !m_pend);
        check("div_clk", oDIV_CLK, run && (m_cnt < (m_d + 1) / 2));
        check("tick", oTICK, run && (m_cnt == 0));
        check("busy", oBUSY, run);
        check("div_cur", oDIV_CUR, m_d);
        check("err", oERR, m_err);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit rst_n, input bit start, input bit stop,
                        input bit valid, input int div);
        RST_N = rst_n; iSTART = start; iSTOP = stop; iDIV_VALID = valid; iDIV = WIDTH'(div);
        @(posedge CLK);
        model_edge(rst_n, start, stop, valid, div);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic cmp_pattern();
        logic [2:0] got;
        logic [2:0] e;
        got = {oDIV_READY, oDIV_CLK, oTICK};
        e = exp_q.pop_front();
        check("pattern", got, e);
    endtask

    task automatic wait_cnt(input int target);
        bit found = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_mode != 0 && m_cnt == target) begin found = 1; break; end
            step(1, 0, 0, 0, 0);
        end
        check("wait_cnt_timeout", found, 1);
    endtask

    task automatic wait_idle();
        bit found = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_mode == 0) begin found = 1; break; end
            step(1, 0, 0, 0, 0);
        end
        check("wait_idle_timeout", found, 1);
    endtask

    task automatic wait_last_stopping();
        bit found = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_mode == 2 && m_cnt == m_d - 1) begin found = 1; break; end
            step(1, 0, 0, 0, 0);
        end
        check("wait_last_timeout", found, 1);
    endtask

    task automatic load_div(input int div);
        step(1, 0, 0, 1, div);
        idle(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST_N = 1'b0; iSTART = 1'b0; iSTOP = 1'b0; iDIV_VALID = 1'b0; iDIV = '0;
        m_shadow = DEF;

        // Reset values
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 3);
        check("rst_cur", oDIV_CUR, 8);
        check("rst_ready", oDIV_READY, 1);
        idle(2);

        // D=4 from idle: 1,1,0,0 with a tick every 4 cycles
        load_div(4);
        repeat (3) begin
            exp_q.push_back(3'b111); exp_q.push_back(3'b110);
            exp_q.push_back(3'b100); exp_q.push_back(3'b100);
        end
        step(1, 1, 0, 0, 0);
        cmp_pattern();
        for (int i = 0; i < 11; i++) begin step(1, 0, 0, 0, 0); cmp_pattern(); end
        step(1, 0, 1, 0, 0);
        wait_idle();

        // D=3: 1,1,0
        load_div(3);
        repeat (3) begin
            exp_q.push_back(3'b111); exp_q.push_back(3'b110); exp_q.push_back(3'b100);
        end
        step(1, 1, 0, 0, 0);
        cmp_pattern();
        for (int i = 0; i < 8; i++) begin step(1, 0, 0, 0, 0); cmp_pattern(); end
        step(1, 0, 1, 0, 0);
        wait_idle();

        // Divisor change at cnt=1 while running with D=4
        load_div(4);
        step(1, 1, 0, 0, 0);
        wait_cnt(1);
        exp_q.push_back(3'b000); exp_q.push_back(3'b000);
        exp_q.push_back(3'b111); exp_q.push_back(3'b110); exp_q.push_back(3'b110);
        exp_q.push_back(3'b100); exp_q.push_back(3'b100);
        step(1, 0, 0, 1, 5);
        cmp_pattern();
        for (int i = 0; i < 6; i++) begin step(1, 0, 0, 0, 0); cmp_pattern(); end
        check("cur_after_change", oDIV_CUR, 5);

        // Stop at cnt=1 completes the period
        wait_cnt(1);
        step(1, 0, 1, 0, 0);
        wait_idle();
        idle(2);

        // Restart during STOPPING, then restart exactly on the last cycle
        step(1, 1, 0, 0, 0);
        wait_cnt(1);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        idle(6);
        step(1, 0, 1, 0, 0);
        wait_last_stopping();
        step(1, 1, 0, 0, 0);
        check("restart_at_boundary_busy", oBUSY, 1);
        idle(3);
        step(1, 0, 1, 0, 0);
        wait_idle();

        // Simultaneous start and stop: stop wins
        step(1, 1, 1, 0, 0);
        idle(1);
        step(1, 1, 0, 0, 0);
        idle(2);
        step(1, 1, 1, 0, 0);
        wait_idle();

        // Illegal divisors
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 0);
        idle(3);

        // Smallest and largest divisors
        load_div(2);
        step(1, 1, 0, 0, 0);
        idle(8);
        step(1, 0, 1, 0, 0);
        wait_idle();
        load_div(255);
        step(1, 1, 0, 0, 0);
        idle(260);
        step(1, 0, 1, 0, 0);
        wait_idle();

        // Reset mid-period with a pending divisor, and mid-handshake
        load_div(6);
        step(1, 1, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 1, 9);
        idle(1);
        step(0, 1, 0, 1, 5);
        idle(4);
        check("pending_lost_cur", oDIV_CUR, 8);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            bit r, s, p, v;
            int d;
            r = ($urandom_range(0, 499) != 0);
            s = ($urandom_range(0, 15) == 0);
            p = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            step(r, s, p, v, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
